seven_seg_scan_ctrl: RTL
========================

// Module: seven_seg_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for a bank of NUM_DIGITS common-anode 7-seg digits sharing one
//   segment bus. Accepts a packed hex word over a valid/ready handshake, double-buffers it, and cycles
//   digit enables with a dead-time gap between digits to prevent ghosting.
//   Optional leading-zero suppression and per-digit blanking. Sits between the datapath and board pins.
// PARAMETERS
//   NUM_DIGITS  4      digits driven; scan order 0 (LSD) .. NUM_DIGITS-1 (MSD)
//   PRESCALE    50000  clk cycles each digit is driven (>=1)
//   GAP         2      clk cycles all anodes off between digits (>=1)
// PORTS
//   clk          in   1              system clock, rising edge
//   resetn       in   1              asynchronous active-low reset
//   load_valid   in   1              load_data/blank_mask/lz_suppress valid
//   load_ready   out  1              pending buffer empty; transfer when load_valid && load_ready
//   load_data    in   4*NUM_DIGITS   nibble i = digit i value
//   blank_mask   in   NUM_DIGITS     1 = digit i forced dark
//   lz_suppress  in   1              1 = blank leading zero digits (digit 0 never suppressed)
//   seg          out  [0:6]          active-low segments, seg[0]=a .. seg[6]=g
//   an           out  NUM_DIGITS     active-low digit enables, at most one low
//   digit_idx    out  clog2(NUM_DIGITS)  index of digit currently in scan slot
//   frame_done   out  1              1-cycle pulse on last cycle of the final GAP of a frame
// BEHAVIOUR
//   Reset (async, resetn=0): seg=7'b1111111, an=all 1, load_ready=1, frame_done=0, digit_idx=0,
//     active and pending buffers cleared (data 0, mask 0, lz 0), FSM=S_DRIVE, prescale counter=0.
//     Reset mid-frame aborts scan immediately; first DRIVE after release is digit 0 showing 0.
//   Buffers: pending (valid flag + data/mask/lz) and active. load_ready = ~pending_valid.
//     Accepted load sets pending_valid next cycle. No accept while pending_valid (load_ready=0).
//   Frame boundary (frame_done cycle): if pending_valid, active<=pending, pending_valid<=0.
//     Load accepted in the frame_done cycle lands in pending (pending was empty) and is shown one
//     frame later. Active never changes mid-frame (no tearing).
//   FSM: S_DRIVE: an[digit_idx]=0, seg=decode(active nibble) or 7'b1111111 if dark; stay PRESCALE
//     cycles, then S_GAP. S_GAP: an=all 1, seg=all 1; stay GAP cycles, then digit_idx increments
//     and FSM returns to S_DRIVE. digit_idx wraps NUM_DIGITS-1 -> 0; frame_done asserted on last
//     GAP cycle of digit NUM_DIGITS-1. Frame length = NUM_DIGITS*(PRESCALE+GAP) cycles.
//   Dark digit i: blank_mask[i]=1, or lz_suppress=1 and i>0 and nibbles i..NUM_DIGITS-1 all zero.
//   seg/an are registered: change on the clock edge entering each state; no combinational path
//     from load_* to any output.
//   Decode (active-low, [0:6]=a..g): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100
//     6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010
//     E=0110000 F=0111000.
//   Counter widths: prescale counter clog2(max(PRESCALE,GAP)+1) bits; no overflow permitted.
// STRUCTURE
//   Shared package seg_pkg: decode table constant SEG_LUT[16], SEG_BLANK=7'b1111111, FSM state
//   encoding {S_DRIVE,S_GAP}. One sub-module natural: seg_scan_timer (prescale counter emitting
//   drive_end/gap_end strobes). Buffers, blanking logic and FSM stay in this module.
// TESTING (NUM_DIGITS=4, PRESCALE=4, GAP=1; frame = 20 cycles)
//   1 Reset: hold resetn=0 -> seg=1111111, an=1111, load_ready=1; release -> an=1110, seg=0000001
//     for 4 cycles, then an=1111 for 1 cycle, then an=1101.
//   2 Load 16'h12AF, mask 0, lz 0 -> after next frame_done: digit0 seg=0111000 (F), digit1 0001000,
//     digit2 0010010, digit3 1001111; frame_done pulses every 20 cycles.
//   3 Backpressure: two back-to-back loads 16'h1111 then 16'h2222 -> second held (load_ready=0)
//     until frame_done; 1111 shown for one full frame, then 2222; no value skipped or torn.
//   4 lz_suppress=1, data 16'h0050 -> digits 3,2 dark (an low, seg=1111111), digit1 shows 5,
//     digit0 shows 0; data 16'h0000 -> only digit0 lit with 0000001.
//   5 blank_mask=4'b0101, data 16'h8888 -> digits 0,2 seg=1111111, digits 1,3 seg=0000000.
//   6 Assert resetn=0 mid-DRIVE of digit 2 with pending full -> outputs reset same cycle
//     (async), load_ready=1, pending discarded; scan restarts at digit 0 showing 0.

Source files
------------

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM state encoding,
// blank pattern and the hex-to-segment decode table.
// Segment vectors are [0:6] = a..g and active-low (0 = segment lit).
package seg_pkg;

  typedef enum logic {
    S_DRIVE = 1'b0,
    S_GAP   = 1'b1
  } scan_state_t;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  // Index = nibble value; glyphs 0-9, A, b, C, d, E, F.
  localparam logic [0:6] SEG_LUT [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load channel of the scan controller: a packed hex word plus per-digit blank
// mask and leading-zero control, transferred when load_valid && load_ready.
// master = datapath side (drives the word), slave = scan controller.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
) ();

  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;    // nibble i = digit i value
  logic [NUM_DIGITS-1:0]   blank_mask;   // 1 = digit i forced dark
  logic                    lz_suppress;  // 1 = blank leading zero digits

  modport master (
    output load_valid,
    output load_data,
    output blank_mask,
    output lz_suppress,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  blank_mask,
    input  lz_suppress,
    output load_ready
  );

endinterface

// File: rtl/seven_seg_scan_ctrl_timer.sv
// seg_scan_timer: slot counter for the scan FSM. Counts cycles spent in the
// current DRIVE or GAP slot and flags the final cycle of each.
// Latency: strobes are combinational from the counter and state flops.
// Backpressure: none; held at zero while en is low.
// Ports: clk/resetn; en (counting allowed); state (current FSM state);
//   drive_end / gap_end (this is the last cycle of the slot);
//   gap_last_nxt (the next cycle will be the last GAP cycle).
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int GAP      = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  scan_state_t state,
  output logic        drive_end,
  output logic        gap_end,
  output logic        gap_last_nxt
);

  localparam int CNT_MAX = (PRESCALE > GAP) ? PRESCALE : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign drive_end = en && (state == S_DRIVE) && (cnt_q == DRIVE_LAST);
  assign gap_end   = en && (state == S_GAP)   && (cnt_q == GAP_LAST);

  // Look-ahead so the owner can register a pulse that lines up with the
  // final GAP cycle: either we enter a one-cycle GAP right now, or the GAP
  // counter is one short of its terminal value.
  assign gap_last_nxt = en && (((GAP == 1) && drive_end) ||
                               ((state == S_GAP) && !gap_end &&
                                ((cnt_q + CNT_W'(1)) == GAP_LAST)));

  always_comb begin
    cnt_d = cnt_q;
    if (drive_end || gap_end) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan of NUM_DIGITS common-anode
// 7-seg digits on a shared segment bus, with a dead-time gap between digits.
// Latency: a loaded word is shown from the frame after the next frame_done;
//   seg/an/frame_done/digit_idx are registered.
// Backpressure: load_ready drops while the pending buffer is full and
//   returns the cycle after the frame_done that moves pending to active.
// Ports: clk, resetn (async, active low); load_if (slave load channel);
//   seg[0:6] active-low a..g; an active-low digit enables;
//   digit_idx current scan slot; frame_done pulse on the frame's final cycle.
module seven_seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int GAP        = 2,
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  seven_seg_scan_ctrl_if.slave  load_if,
  output logic [0:6]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_done
);

  localparam int               DATA_W   = 4 * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------
  // Double buffer
  // ---------------------------------------------------------------------
  logic                  pend_vld_q,  pend_vld_d;
  logic [DATA_W-1:0]     pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0] pend_mask_q, pend_mask_d;
  logic                  pend_lz_q,   pend_lz_d;
  logic [DATA_W-1:0]     act_data_q,  act_data_d;
  logic [NUM_DIGITS-1:0] act_mask_q,  act_mask_d;
  logic                  act_lz_q,    act_lz_d;
  logic                  load_fire;

  // ---------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------
  scan_state_t           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  started_q, started_d;
  logic [0:6]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;
  logic                  drive_end, gap_end, gap_last_nxt;
  logic [NUM_DIGITS-1:0] dark;
  logic                  zero_run;
  logic [3:0]            nib_sel;

  assign load_if.load_ready = ~pend_vld_q;
  assign load_fire          = load_if.load_valid && !pend_vld_q;

  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    pend_mask_d = pend_mask_q;
    pend_lz_d   = pend_lz_q;
    act_data_d  = act_data_q;
    act_mask_d  = act_mask_q;
    act_lz_d    = act_lz_q;
    // Active only changes on the frame's last cycle, so a frame is never torn.
    if (frame_done_q && pend_vld_q) begin
      act_data_d = pend_data_q;
      act_mask_d = pend_mask_q;
      act_lz_d   = pend_lz_q;
      pend_vld_d = 1'b0;
    end
    // Accept and promote are mutually exclusive: accept needs pending empty.
    if (load_fire) begin
      pend_vld_d  = 1'b1;
      pend_data_d = load_if.load_data;
      pend_mask_d = load_if.blank_mask;
      pend_lz_d   = load_if.lz_suppress;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      pend_mask_q <= '0;
      pend_lz_q   <= 1'b0;
      act_data_q  <= '0;
      act_mask_q  <= '0;
      act_lz_q    <= 1'b0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      pend_mask_q <= pend_mask_d;
      pend_lz_q   <= pend_lz_d;
      act_data_q  <= act_data_d;
      act_mask_q  <= act_mask_d;
      act_lz_q    <= act_lz_d;
    end
  end

  // Dark digits, evaluated on the buffer contents that the next cycle will
  // display. zero_run tracks "this nibble and every more significant one is
  // zero"; digit 0 is never leading-zero suppressed.
  always_comb begin
    zero_run = 1'b1;
    dark     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_data_d[4*i +: 4] == 4'h0);
      dark[i]  = act_mask_d[i] || (act_lz_d && (i > 0) && zero_run);
    end
  end

  seg_scan_timer #(
    .PRESCALE (PRESCALE),
    .GAP      (GAP)
  ) u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .en           (started_q),
    .state        (state_q),
    .drive_end    (drive_end),
    .gap_end      (gap_end),
    .gap_last_nxt (gap_last_nxt)
  );

  // Outputs are computed from the next state so they change on the edge
  // that enters each state. started_q holds the timer for the one cycle in
  // which the outputs climb out of their reset values, giving digit 0 its
  // full PRESCALE-cycle slot after reset.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    started_d = 1'b1;
    if (started_q) begin
      case (state_q)
        S_DRIVE: begin
          if (drive_end) begin
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (gap_end) begin
            state_d = S_DRIVE;
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
          end
        end
        default: state_d = S_DRIVE;
      endcase
    end

    nib_sel = act_data_d[{idx_d, 2'b00} +: 4];
    seg_d   = SEG_BLANK;
    an_d    = '1;
    if (state_d == S_DRIVE) begin
      an_d[idx_d] = 1'b0;
      if (!dark[idx_d]) begin
        seg_d = SEG_LUT[nib_sel];
      end
    end

    // digit_idx is unchanged across a DRIVE->GAP or GAP->GAP step.
    frame_done_d = gap_last_nxt && (idx_q == LAST_IDX);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_DRIVE;
      idx_q        <= '0;
      started_q    <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      started_q    <= started_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule
